// File: rtl/tree_vote_sequencer.sv
// Runs one shared decision-tree bank over a held feature vector, one tree per cycle, and reports a thresholded vote.
// Optional macro TREE_VOTE_EARLY_EXIT_EN: stop evaluating as soon as the decision can no longer change.
module tree_vote_sequencer #(
   parameter  int FEAT_W      = 51,
   parameter  int N_TREES     = 8,
   parameter  int SEL_W       = 3,
   parameter  int VOTE_THRESH = 5,
   localparam int CNT_W       = $clog2(N_TREES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [FEAT_W-1:0] s_feat,
   output logic [FEAT_W-1:0] feat_o,
   output logic [SEL_W-1:0]  tree_sel,
   input  logic              tree_vote,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_class,
   output logic [CNT_W-1:0]  m_votes,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_TREES - 1);
   localparam logic [CNT_W-1:0] THRESH   = CNT_W'(VOTE_THRESH);

   state_t           state, state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] new_count;
   logic             load;
   logic             finish;
   logic             early;

`ifdef TREE_VOTE_EARLY_EXIT_EN
   logic [CNT_W:0]   reach;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      finish     = 1'b0;
      new_count  = count + CNT_W'(tree_vote);
`ifdef TREE_VOTE_EARLY_EXIT_EN
      // Best reachable total if every remaining tree voted 1.
      reach      = {1'b0, new_count} + (CNT_W+1)'(LAST_SEL - tree_sel);
      early      = (new_count >= THRESH) || (reach < (CNT_W+1)'(VOTE_THRESH));
`else
      early      = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (s_valid) begin
               load       = 1'b1;
               state_next = EVAL;
            end
         end
         EVAL: begin
            finish = (tree_sel == LAST_SEL) || early;
            if (finish) state_next = DONE;
         end
         DONE: begin
            if (m_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feat_o   <= '0;
         tree_sel <= '0;
         count    <= '0;
         m_votes  <= '0;
         m_class  <= 1'b0;
      end else if (load) begin
         feat_o   <= s_feat;
         tree_sel <= '0;
         count    <= '0;
      end else if (state == EVAL) begin
         count <= new_count;
         if (finish) begin
            m_votes <= new_count;
            m_class <= (new_count >= THRESH);
         end else begin
            tree_sel <= tree_sel + SEL_W'(1);
         end
      end
   end

   assign s_ready = (state == IDLE);
   assign m_valid = (state == DONE);
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_tree_vote_sequencer.sv
// Self-checking bench for tree_vote_sequencer: directed and random vote patterns against a vote-counting reference model.
module tb_tree_vote_sequencer;

   localparam int FEAT_W      = 51;
   localparam int N_TREES     = 8;
   localparam int SEL_W       = 3;
   localparam int VOTE_THRESH = 5;
   localparam int CNT_W       = $clog2(N_TREES + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [FEAT_W-1:0] s_feat;
   logic [FEAT_W-1:0] feat_o;
   logic [SEL_W-1:0]  tree_sel;
   logic              tree_vote;
   logic              m_valid;
   logic              m_ready;
   logic              m_class;
   logic [CNT_W-1:0]  m_votes;
   logic              busy;

   logic [N_TREES-1:0] votes_vec;
   logic [FEAT_W-1:0]  rfeat;
   int                 passes = 0;
   int                 total  = 0;

   tree_vote_sequencer #(
      .FEAT_W(FEAT_W), .N_TREES(N_TREES), .SEL_W(SEL_W), .VOTE_THRESH(VOTE_THRESH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_feat(s_feat),
      .feat_o(feat_o), .tree_sel(tree_sel), .tree_vote(tree_vote), .m_valid(m_valid),
      .m_ready(m_ready), .m_class(m_class), .m_votes(m_votes), .busy(busy)
   );

   always #5 clk = ~clk;

   // Tree bank stand-in: tree i votes votes_vec[i].
   assign tree_vote = (int'(tree_sel) < N_TREES) ? votes_vec[tree_sel] : 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: count votes tree by tree; with early exit, stop once the threshold is met or out of reach.
   function automatic void model(input logic [N_TREES-1:0] v, output int votes, output bit cls,
                                 output int cycles);
      votes  = 0;
      cycles = N_TREES;
      for (int i = 0; i < N_TREES; i++) begin
         votes += int'(v[i]);
`ifdef TREE_VOTE_EARLY_EXIT_EN
         if (votes >= VOTE_THRESH || votes + (N_TREES - 1 - i) < VOTE_THRESH) begin
            cycles = i + 1;
            break;
         end
`endif
      end
      cls = (votes >= VOTE_THRESH);
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_s_ready"},  64'(s_ready),  64'd1);
      check({tag, "_m_valid"},  64'(m_valid),  64'd0);
      check({tag, "_busy"},     64'(busy),     64'd0);
      check({tag, "_feat_o"},   64'(feat_o),   64'd0);
      check({tag, "_tree_sel"}, 64'(tree_sel), 64'd0);
      check({tag, "_m_votes"},  64'(m_votes),  64'd0);
      check({tag, "_m_class"},  64'(m_class),  64'd0);
   endtask

   // One transaction from IDLE: accept, walk the trees, hold DONE for `hold` cycles, hand off.
   task automatic run_sample(input logic [FEAT_W-1:0] feat, input logic [N_TREES-1:0] v,
                             input int hold, input bit stray);
      int ev, n, cyc;
      bit cls;
      model(v, ev, cls, n);
      votes_vec = v;
      m_ready   = (hold == 0);
      check("idle_s_ready", 64'(s_ready), 64'd1);
      s_valid = 1'b1;
      s_feat  = feat;
      @(negedge clk);
      if (stray) s_feat = ~feat;
      else       s_valid = 1'b0;
      cyc = 0;
      while (!m_valid && cyc <= N_TREES + 2) begin
         check("eval_busy",     64'(busy),     64'd1);
         check("eval_s_ready",  64'(s_ready),  64'd0);
         check("eval_tree_sel", 64'(tree_sel), 64'(cyc));
         check("eval_feat_o",   64'(feat_o),   64'(feat));
         cyc++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      check("eval_cycles", 64'(cyc),     64'(n));
      check("done_m_valid", 64'(m_valid), 64'd1);
      check("done_m_votes", 64'(m_votes), 64'(ev));
      check("done_m_class", 64'(m_class), 64'(cls));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_m_valid",  64'(m_valid),  64'd1);
         check("hold_m_votes",  64'(m_votes),  64'(ev));
         check("hold_m_class",  64'(m_class),  64'(cls));
         check("hold_s_ready",  64'(s_ready),  64'd0);
         check("hold_tree_sel", 64'(tree_sel), 64'(n - 1));
      end
      m_ready = 1'b1;
      @(negedge clk);
      check("after_m_valid", 64'(m_valid), 64'd0);
      check("after_s_ready", 64'(s_ready), 64'd1);
      check("after_busy",    64'(busy),    64'd0);
      check("after_m_votes", 64'(m_votes), 64'(ev));
      check("after_m_class", 64'(m_class), 64'(cls));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      s_valid   = 1'b0;
      s_feat    = '0;
      m_ready   = 1'b0;
      votes_vec = '0;
      repeat (2) @(negedge clk);
      check_reset_values("in_reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_values("idle");

      // Trees 0-4 vote 1, 5-7 vote 0.
      run_sample(51'h1, 8'b0001_1111, 0, 1'b0);
      // Alternating votes with a competing sample offered throughout EVAL.
      rfeat = FEAT_W'({$urandom, $urandom});
      run_sample(rfeat, 8'b0101_0101, 0, 1'b1);
      // Downstream backpressure for 10 cycles.
      rfeat = FEAT_W'({$urandom, $urandom});
      run_sample(rfeat, 8'hA5, 10, 1'b1);

      // Reset asserted mid-evaluation.
      votes_vec = '1;
      m_ready   = 1'b1;
      s_valid   = 1'b1;
      s_feat    = FEAT_W'({$urandom, $urandom});
      @(negedge clk);
      s_valid = 1'b0;
      for (int k = 0; k < N_TREES && tree_sel != SEL_W'(3); k++) @(negedge clk);
      check("pre_reset_tree_sel", 64'(tree_sel), 64'd3);
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_reset_m_valid", 64'(m_valid), 64'd0);
         check("post_reset_s_ready", 64'(s_ready), 64'd1);
      end

      run_sample(51'h7_FFFF_0000_1234, 8'hFF, 0, 1'b0);
      run_sample(51'h2_AAAA_5555_0F0F, 8'h00, 0, 1'b0);
      for (int t = 0; t < 8; t++) begin
         rfeat = FEAT_W'({$urandom, $urandom});
         run_sample(rfeat, N_TREES'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/tree_vote_sequencer.md
Name: tree_vote_sequencer

Overview:
- Sequences one shared, time-multiplexed bank of combinational decision-tree classifiers (e.g. class1_tree0..N) over one feature vector.
- Accepts a sample on a valid/ready input and holds it stable on feat_o.
- Steps tree_sel through the trees one per cycle and accumulates each 1-bit vote.
- Emits a thresholded class decision and the vote count on a valid/ready output.

Parameters:
FEAT_W, 51, feature vector width (matches tree input i[50:0])
N_TREES, 8, number of trees in the ensemble, >=1
SEL_W, 3, tree_sel width, must satisfy 2**SEL_W >= N_TREES
VOTE_THRESH, 5, m_class=1 when vote count >= VOTE_THRESH, range 1..N_TREES
(localparam CNT_W = $clog2(N_TREES+1))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept sample
s_feat  in  FEAT_W  input feature vector
feat_o  out  FEAT_W  registered sample driven to the tree bank
tree_sel  out  SEL_W  index of tree currently evaluated
tree_vote  in  1  combinational output of selected tree for feat_o
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_class  out  1  ensemble decision
m_votes  out  CNT_W  number of trees that voted 1
busy  out  1  high in EVAL or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE; feat_o=0, tree_sel=0, count=0, m_valid=0, m_class=0, m_votes=0, s_ready=1, busy=0.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - s_ready=1.
  - On s_valid: feat_o<=s_feat, count<=0, tree_sel<=0, go to EVAL.
- EVAL:
  - s_ready=0.
  - Each cycle: count<=count+tree_vote, sampled at the edge for the current tree_sel.
  - If tree_sel==N_TREES-1: latch m_votes=final count and m_class=(final count>=VOTE_THRESH), go to DONE. Otherwise tree_sel<=tree_sel+1.
  - feat_o is stable for the whole of EVAL.
- DONE:
  - m_valid=1; m_class and m_votes are held until m_ready is seen.
  - On m_ready: m_valid<=0, go to IDLE.
  - tree_sel holds its last value.
- Latency: accept edge to m_valid high is N_TREES+1 cycles.
- Throughput: one sample per N_TREES+2 cycles with m_ready tied high. No accept in DONE (s_ready=0).
- Count never overflows: CNT_W holds N_TREES.
- m_class/m_votes are registered outputs. They keep their values after handshake until the next result is latched.
- Backpressure: m_ready low holds DONE indefinitely. Input s_valid is ignored until back in IDLE; the upstream holds its data.
- N_TREES=1: EVAL lasts exactly one cycle.
- Reset mid-EVAL/DONE: in-flight sample and result are discarded; no m_valid pulse.
- tree_vote is don't-care outside EVAL.

Optional Feature:
Macro TREE_VOTE_EARLY_EXIT_EN.
- Defined: in EVAL, finish early once the decision is settled:
  - new_count>=VOTE_THRESH → m_class=1, or
  - new_count + (N_TREES-1-tree_sel) < VOTE_THRESH → m_class=0.
  - Latch m_votes=new_count (partial count) and go to DONE that cycle.
- Undefined: all N_TREES are always evaluated. m_votes is the full count; latency is fixed.

Test Plan:
- Reset then idle → s_ready=1, m_valid=0, busy=0, feat_o=0, tree_sel=0.
- Accept s_feat=51'h1, tree_vote=1 for trees 0-4 and 0 for 5-7, m_ready=1 → tree_sel steps 0..7; m_valid at cycle 9 after accept; m_votes=5, m_class=1; return to IDLE.
- Votes 1,0,1,0,1,0,1,0 → m_votes=4, m_class=0; s_valid during EVAL is not accepted (s_ready=0) and feat_o is unchanged.
- m_ready held low 10 cycles in DONE → m_valid, m_class, m_votes stable; no new sample accepted; release m_ready → IDLE next cycle, s_ready=1.
- rst_n low at tree_sel=3 → immediate return to reset values; no m_valid; next sample processed normally with count starting at 0.
- TREE_VOTE_EARLY_EXIT_EN defined, all votes 1 → DONE after tree_sel=4, m_votes=5, m_class=1. All votes 0 → DONE after tree_sel=3 (0+4<5), m_votes=0, m_class=0.
